// File: rtl/frame_feeder_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | frame_feeder_if : frame request, upstream stream and buffer port   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface frame_feeder_if #(
  parameter int LEN_W = 8
);
  logic             start;
  logic [LEN_W-1:0] frame_len;
  logic [15:0]      in_data;
  logic             in_valid;
  logic             in_ready;
  logic             buffer_full;
  logic [15:0]      data_1;
  logic             data_1_en;
  logic             busy;
  logic             frame_done;

  modport master (
    output start, frame_len, in_data, in_valid, buffer_full,
    input  in_ready, data_1, data_1_en, busy, frame_done
  );

  modport slave (
    input  start, frame_len, in_data, in_valid, buffer_full,
    output in_ready, data_1, data_1_en, busy, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/frame_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | frame_feeder : writes header / payload / checksum frames to buffer |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module frame_feeder #(
  parameter int         LEN_W = 8,
  parameter logic [7:0] MAGIC = 8'hA5
) (
  input  wire logic      clk_1,
  input  wire logic      rst,
  frame_feeder_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PAY  = 2'd2,
    TRL  = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_ZERO = '0;

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic [15:0]      csum;
  logic             done_q;
  logic [7:0]       len_byte;
  logic [15:0]      data_out;
  logic             wr_en;
  logic             rdy;

  // Header carries the low byte of the length; narrow lengths are zero-extended.
  generate
    if (LEN_W >= 8) begin : g_len_trunc
      assign len_byte = len_q[7:0];
    end else begin : g_len_zext
      assign len_byte = {{(8-LEN_W){1'b0}}, len_q};
    end
  endgenerate

  always_comb begin
    data_out = 16'h0000;
    wr_en    = 1'b0;
    rdy      = 1'b0;
    case (state)
      HDR: begin
        data_out = {MAGIC, len_byte};
        wr_en    = ~bus.buffer_full;
      end
      PAY: begin
        rdy      = ~bus.buffer_full;
        data_out = bus.in_data;
        wr_en    = bus.in_valid & ~bus.buffer_full;
      end
      TRL: begin
        data_out = csum;
        wr_en    = ~bus.buffer_full;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      len_q  <= '0;
      cnt    <= '0;
      csum   <= 16'h0000;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && (bus.frame_len != LEN_ZERO)) begin
            len_q <= bus.frame_len;
            cnt   <= '0;
            csum  <= 16'h0000;
            state <= HDR;
          end
        end
        HDR: begin
          if (!bus.buffer_full) state <= PAY;
        end
        PAY: begin
          // Transfer only when the same word is also written to the buffer.
          if (bus.in_valid && !bus.buffer_full) begin
            csum <= csum + bus.in_data;
            cnt  <= cnt + LEN_ONE;
            if (cnt == len_q - LEN_ONE) state <= TRL;
          end
        end
        TRL: begin
          if (!bus.buffer_full) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.data_1     = data_out;
  assign bus.data_1_en  = wr_en;
  assign bus.in_ready   = rdy;
  assign bus.busy       = (state != IDLE);
  assign bus.frame_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_frame_feeder : randomized frames checked against a frame model  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_frame_feeder;
  localparam int         LEN_W = 8;
  localparam logic [7:0] MAGIC = 8'hA5;

  logic clk_1 = 1'b0;
  logic rst;
  always #5 clk_1 = ~clk_1;

  frame_feeder_if #(.LEN_W(LEN_W)) bus();

  frame_feeder #(.LEN_W(LEN_W), .MAGIC(MAGIC)) dut (
    .clk_1 (clk_1),
    .rst   (rst),
    .bus   (bus.slave)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] payload_q[$];
  logic [63:0] full_mask;
  logic [63:0] gap_mask;

  // Everything the DUT writes into the buffer, in order.
  always @(posedge clk_1) begin
    if (bus.data_1_en === 1'b1) got_q.push_back(bus.data_1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_tests++;
    if (obs !== req) begin
      n_fail++;
      $display("FAIL %s: observed %0h required %0h", tag, obs, req);
    end
  endtask

  // Frame model: header, payload in order, 16-bit wrapped sum.
  task automatic build_expected(input int len);
    int sum = 0;
    exp_q.delete();
    exp_q.push_back({MAGIC, 8'(len)});
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(payload_q[i]);
      sum = (sum + int'(payload_q[i])) % 65536;
    end
    exp_q.push_back(16'(sum));
  endtask

  // Runs one frame; returns at posedge+1 of the frame_done cycle when chain_next is set.
  task automatic run_frame(input int len, input int gap_pct, input int full_pct,
                           input bit strict, input bit chained, input bit chain_next,
                           input bit start_mid);
    int idx = 0;
    int done_k = 0;
    int bound;
    while (payload_q.size() < len) payload_q.push_back(16'($urandom));
    build_expected(len);
    got_q.delete();
    bound = len * 40 + 60;
    if (!chained) begin
      bus.start     = 1'b1;
      bus.frame_len = LEN_W'(len);
    end
    @(posedge clk_1); #1;
    bus.start = 1'b0;
    for (int k = 1; k <= bound; k++) begin
      if (bus.frame_done === 1'b1) begin
        done_k = k;
        break;
      end
      bus.buffer_full = ((k < 64) ? full_mask[k] : 1'b0) || (int'($urandom_range(99)) < full_pct);
      bus.in_valid    = (idx < len) && !((k < 64) ? gap_mask[k] : 1'b0)
                        && (int'($urandom_range(99)) >= gap_pct);
      bus.in_data     = (idx < len) ? payload_q[idx] : 16'($urandom);
      if (start_mid && k == 3) begin
        bus.start     = 1'b1;
        bus.frame_len = LEN_W'(5);
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk_1);
      check("busy_in_frame", bus.busy, 1);
      if (bus.buffer_full) check("full_blocks", {bus.data_1_en, bus.in_ready}, 0);
      if (bus.in_ready) begin
        check("pay_data", bus.data_1, bus.in_data);
        check("pay_en", bus.data_1_en, bus.in_valid);
      end
      if (strict) check("en_timing", bus.data_1_en, (k <= len + 2) ? 1 : 0);
      if (bus.in_valid && bus.in_ready) idx++;
      @(posedge clk_1); #1;
    end
    bus.in_valid    = 1'b0;
    bus.buffer_full = 1'b0;
    bus.start       = 1'b0;
    check("done_seen", (done_k != 0) ? 1 : 0, 1);
    if (strict) check("done_cycle", done_k, len + 3);
    if (!chain_next) begin
      @(posedge clk_1); #1;
      check("done_pulse", bus.frame_done, 0);
      check("busy_after", bus.busy, 0);
    end
    check("n_writes", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("word%0d", i), got_q[i], exp_q[i]);
    payload_q.delete();
    full_mask = '0;
    gap_mask  = '0;
  endtask

  initial begin
    rst             = 1'b1;
    bus.start       = 1'b0;
    bus.frame_len   = '0;
    bus.in_data     = 16'h0000;
    bus.in_valid    = 1'b0;
    bus.buffer_full = 1'b0;
    full_mask       = '0;
    gap_mask        = '0;
    repeat (2) @(negedge clk_1);
    bus.in_valid = 1'b1;
    bus.start    = 1'b1;
    bus.frame_len = 8'd3;
    #1;
    check("rst_en", bus.data_1_en, 0);
    check("rst_data", bus.data_1, 0);
    check("rst_ready", bus.in_ready, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.frame_done, 0);
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk_1); #1;
    rst = 1'b0;
    @(posedge clk_1); #1;

    // Basic frame with exact latency.
    payload_q = '{16'h0001, 16'h0002, 16'h0003};
    run_frame(3, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Backpressure on the second payload word.
    full_mask = (64'd1 << 3) | (64'd1 << 4) | (64'd1 << 5);
    run_frame(4, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Checksum wrap plus a held trailer.
    payload_q = '{16'hFFFF, 16'h0003};
    full_mask = (64'd1 << 4) | (64'd1 << 5);
    run_frame(2, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Upstream gaps 1,0,1,0,1.
    gap_mask = (64'd1 << 3) | (64'd1 << 5);
    run_frame(3, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Start during payload is ignored.
    run_frame(6, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1);

    // Zero-length start is ignored.
    got_q.delete();
    bus.start     = 1'b1;
    bus.frame_len = '0;
    @(posedge clk_1); #1;
    bus.start = 1'b0;
    repeat (3) begin
      @(negedge clk_1);
      check("zero_busy", bus.busy, 0);
      check("zero_en", bus.data_1_en, 0);
      @(posedge clk_1); #1;
    end
    check("zero_done", bus.frame_done, 0);
    check("zero_writes", got_q.size(), 0);

    // Reset after header and one payload word.
    got_q.delete();
    bus.start     = 1'b1;
    bus.frame_len = 8'd3;
    @(posedge clk_1); #1;
    bus.start       = 1'b0;
    bus.in_valid    = 1'b1;
    bus.in_data     = 16'h0BAD;
    bus.buffer_full = 1'b0;
    @(posedge clk_1); #1;
    @(posedge clk_1); #1;
    rst = 1'b1;
    #1;
    check("midrst_en", bus.data_1_en, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.frame_done, 0);
    check("midrst_writes", got_q.size(), 2);
    bus.in_valid = 1'b0;
    @(posedge clk_1); #1;
    rst = 1'b0;
    @(posedge clk_1); #1;
    payload_q = '{16'h1234};
    run_frame(1, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Back-to-back: second start in the frame_done cycle.
    run_frame(2, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    bus.start     = 1'b1;
    bus.frame_len = 8'd1;
    run_frame(1, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Randomized frames with gaps and backpressure.
    for (int f = 0; f < 25; f++)
      run_frame(int'($urandom_range(24, 1)), 30, 25, 1'b0, 1'b0, 1'b0, 1'b0);

    // Longest frame.
    run_frame(255, 10, 10, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/frame_feeder.md
Name: frame_feeder

Overview:
- Write-side producer for the dual-clock 16-bit buffer. Runs on clk_1 and drives that buffer's data_1/data_1_en write port, obeying its buffer_full flag.
- Accepts a frame request (start + length), then pulls payload words from an upstream valid/ready stream.
- Emits a framed word sequence into the buffer: header word, payload words, then a 16-bit checksum trailer. The read side on clk_2 sees complete frames.

Parameters:
- LEN_W, 8, width of frame_len; max payload length 2^LEN_W-1
- MAGIC, 8'hA5, upper byte of the header word

Ports:
- clk_1  input  1  write-domain clock; all state on posedge
- rst  input  1  asynchronous, active-high reset
- start  input  1  frame request; sampled in IDLE only
- frame_len  input  LEN_W  payload word count; latched on accepted start
- in_data  input  16  upstream payload word
- in_valid  input  1  upstream word valid
- in_ready  output  1  block accepts in_data this cycle
- buffer_full  input  1  full flag from buffer (clk_1 domain)
- data_1  output  16  word to buffer
- data_1_en  output  1  buffer write strobe; one word per asserted cycle
- busy  output  1  frame in progress
- frame_done  output  1  one-cycle pulse after trailer written

Behaviour:
- State machine states: IDLE, HDR, PAY, TRL. Registers: state, len_q, cnt (LEN_W bits), csum (16 bits), frame_done.
- Reset values (async, immediate): state=IDLE, len_q=0, cnt=0, csum=0, frame_done=0. While in reset, data_1=0, data_1_en=0, in_ready=0, busy=0.
- data_1, data_1_en and in_ready are combinational from state, buffer_full and in_valid (Mealy). A write occurs only on an edge where buffer_full=0 in that same cycle. No registered look-ahead.
- IDLE:
  - data_1=0, data_1_en=0, in_ready=0, busy=0.
  - start=1 and frame_len!=0: len_q<=frame_len, cnt<=0, csum<=0, go to HDR.
  - start with frame_len=0: ignored; stay IDLE; no frame_done.
- HDR:
  - data_1={MAGIC, len_q[7:0]}; for LEN_W<8, len_q is zero-extended.
  - data_1_en=~buffer_full.
  - On write: go to PAY.
- PAY:
  - in_ready=~buffer_full; data_1=in_data; data_1_en=in_valid & ~buffer_full.
  - Transfer means in_valid & in_ready. On transfer: csum<=csum+in_data (mod 2^16, carry discarded) and cnt<=cnt+1.
  - If cnt==len_q-1 on a transfer: go to TRL.
  - in_valid low or buffer_full high: hold; no write, csum and cnt unchanged.
- TRL:
  - data_1=csum; data_1_en=~buffer_full.
  - On write: go to IDLE; frame_done<=1 for exactly the next cycle.
- busy=1 in HDR, PAY, TRL.
- in_ready=0 outside PAY. Upstream words are never consumed outside the payload phase.
- Latency: start accepted at edge 0. With no backpressure, the header is written at edge 1 and the payload at edges 2..N+1. The trailer is written at edge N+2, and frame_done is high in the cycle after it. A frame totals N+2 buffer writes.
- start while busy: ignored; no queuing.
- start in the frame_done cycle: accepted, since state is already IDLE. Back-to-back frames need no idle gap beyond that.
- buffer_full asserted mid-word: the current word is held on data_1 (HDR/TRL) or left with upstream (PAY). It is written on the first cycle buffer_full=0. No word is ever dropped or duplicated.
- Reset mid-frame: frame abandoned and no trailer emitted. The partial frame already in the buffer is the system's responsibility, since the buffer also resets on rst.

Test Plan:
- Basic frame: start, frame_len=3, payload 0x0001,0x0002,0x0003 with in_valid high and buffer_full=0. Required: data_1_en on 5 consecutive cycles with data_1=0xA503,0x0001,0x0002,0x0003,0x0006; then frame_done=1 for one cycle; busy low.
- Backpressure: frame_len=4, buffer_full held high for 3 cycles while the 2nd payload word is offered. Required: data_1_en=0 and in_ready=0 for those cycles; word 2 is written once after release; trailer equals the sum of all 4 words; total 6 writes.
- Checksum wrap: frame_len=2, payload 0xFFFF,0x0003. Required: trailer 0x0002. Also buffer_full high during TRL for 2 cycles: trailer held, then written once.
- Upstream gaps and ignored starts:
  - frame_len=3 with in_valid toggling 1,0,1,0,1: exactly 3 payload writes, in payload order, and no write on gap cycles.
  - start pulsed during PAY: ignored; the frame completes normally.
  - start with frame_len=0: no write, busy stays 0.
- Reset mid-frame: assert rst after the header and 1 payload word. Required: data_1_en=0, busy=0, frame_done=0 immediately. After release, start with frame_len=1 and payload 0x1234 yields 0xA501,0x1234,0x1234.
- Back-to-back: second start (frame_len=1) asserted in the frame_done cycle. Required: header of frame 2 written on the next edge with no extra idle cycle.
